// File: rtl/kbd_csr_ctrl.sv
// kbd_csr_ctrl: CPU-side controller for the PS/2 keyboard interface.
// Drains key codes from the interface into a type-ahead FIFO, exposes them
// through the BK keyboard CSR (177660) and data register (177662), and
// raises the keyboard interrupt (vector 060, or 0274 for AR2 keys).
//
// Capture FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for kbd_available with room in the FIFO
//   ST_TAKE | read_kb pulse; {ar2, ascii} pushed into the FIFO
//   ST_CLR  | waiting for the interface to drop its stale kbd_available
module kbd_csr_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] VEC_NORMAL = 8'o060,
    parameter logic [7:0] VEC_AR2    = 8'o274
) (
    input  logic                        mclk25,
    input  logic                        reset_in,
    input  logic                        kbd_available,
    input  logic [6:0]                  ascii,
    input  logic                        ar2,
    input  logic                        key_down,
    output logic                        read_kb,
    input  logic                        bus_sel_csr,
    input  logic                        bus_sel_data,
    input  logic                        bus_rd,
    input  logic                        bus_wr,
    input  logic [15:0]                 bus_wdata,
    output logic [15:0]                 bus_rdata,
    output logic                        irq,
    output logic [7:0]                  irq_vector,
    input  logic                        irq_ack,
    output logic                        key_pressed,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;

    logic          mask;
    logic          mask_nxt;
    logic          pending;
    logic          pending_nxt;
    logic [6:0]    hold;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          csr_wr;
    logic          irq_set;
    logic          irq_clr;
    logic [7:0]    head;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rd_ptr];

    // The CSR select has priority, so a data pop only happens when it alone is selected.
    assign pop    = bus_sel_data && !bus_sel_csr && bus_rd && !empty;
    assign csr_wr = bus_sel_csr && bus_wr;
    assign push   = read_kb;

    // Capture FSM state register.
    always_ff @(posedge mclk25) begin
        if (reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (kbd_available && !full) begin
                    state_nxt = ST_TAKE;
                end
            end
            ST_TAKE: begin
                state_nxt = ST_CLR;
            end
            ST_CLR: begin
                if (!kbd_available) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture FSM outputs: the acknowledge is exactly the TAKE cycle.
    always_comb begin
        read_kb = (state == ST_TAKE);
    end

    // Occupancy, mask and interrupt-pending next values.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end

        mask_nxt = csr_wr ? bus_wdata[6] : mask;

        // New-entry and leftover-entry events only count if the resulting mask is open.
        irq_set = (!mask_nxt && ((push && empty) || (pop && (count_nxt != '0))))
                || (csr_wr && mask && !bus_wdata[6] && !empty);
        irq_clr = irq_ack || pop || (csr_wr && bus_wdata[6]);

        pending_nxt = pending;
        if (irq_set) begin
            pending_nxt = 1'b1;
        end else if (irq_clr) begin
            pending_nxt = 1'b0;
        end
    end

    // Control registers: pointers, occupancy, mask, pending, hold, key_pressed.
    always_ff @(posedge mclk25) begin
        if (reset_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mask        <= 1'b0;
            pending     <= 1'b0;
            hold        <= '0;
            key_pressed <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                hold   <= head[6:0];
            end
            count       <= count_nxt;
            mask        <= mask_nxt;
            pending     <= pending_nxt;
            key_pressed <= key_down;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every use.
    always_ff @(posedge mclk25) begin
        if (push) begin
            mem[wr_ptr] <= {ar2, ascii};
        end
    end

    // Bus read mux, combinational from the selects.
    always_comb begin
        bus_rdata = '0;
        if (bus_sel_csr) begin
            bus_rdata = {8'b0, !empty, mask, 6'b0};
        end else if (bus_sel_data) begin
            bus_rdata = {9'b0, (empty ? hold : head[6:0])};
        end
    end

    // Interrupt outputs; the head only moves on a pop, which also clears or re-arms pending.
    always_comb begin
        irq        = pending;
        irq_vector = head[7] ? VEC_AR2 : VEC_NORMAL;
        fifo_level = count;
    end

endmodule

// File: tb/tb_kbd_csr_ctrl.sv
// tb_kbd_csr_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model of kbd_csr_ctrl.
module tb_kbd_csr_ctrl;

    localparam int DEPTH = 4;

    logic        mclk25;
    logic        reset_in;
    logic        kbd_available;
    logic [6:0]  ascii;
    logic        ar2;
    logic        key_down;
    logic        read_kb;
    logic        bus_sel_csr;
    logic        bus_sel_data;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        irq;
    logic [7:0]  irq_vector;
    logic        irq_ack;
    logic        key_pressed;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    kbd_csr_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .VEC_NORMAL(8'o060),
        .VEC_AR2   (8'o274)
    ) dut (
        .mclk25       (mclk25),
        .reset_in     (reset_in),
        .kbd_available(kbd_available),
        .ascii        (ascii),
        .ar2          (ar2),
        .key_down     (key_down),
        .read_kb      (read_kb),
        .bus_sel_csr  (bus_sel_csr),
        .bus_sel_data (bus_sel_data),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .irq          (irq),
        .irq_vector   (irq_vector),
        .irq_ack      (irq_ack),
        .key_pressed  (key_pressed),
        .fifo_level   (fifo_level)
    );

    initial mclk25 = 1'b0;
    always #5 mclk25 = ~mclk25;

    typedef struct packed {
        logic        avail;
        logic [6:0]  code;
        logic        a2;
        logic        kd;
        logic        scsr;
        logic        sdat;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic        ack;
        logic        e_rkb;
        logic [2:0]  e_lvl;
        logic        e_irq;
        logic [7:0]  e_vec;
        logic        e_kp;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic vec_t mkv(input logic avail, input logic [6:0] code, input logic a2,
                                 input logic kd, input logic scsr, input logic sdat,
                                 input logic rd, input logic wr, input logic [15:0] wdata,
                                 input logic ack, input logic e_rkb, input logic [2:0] e_lvl,
                                 input logic e_irq, input logic [7:0] e_vec, input logic e_kp,
                                 input logic [15:0] e_rdata);
        vec_t v;
        v = '{avail, code, a2, kd, scsr, sdat, rd, wr, wdata, ack,
              e_rkb, e_lvl, e_irq, e_vec, e_kp, e_rdata};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic idle_bus();
        bus_sel_csr  = 1'b0;
        bus_sel_data = 1'b0;
        bus_rd       = 1'b0;
        bus_wr       = 1'b0;
        bus_wdata    = 16'h0;
        irq_ack      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge mclk25);
        reset_in      = 1'b1;
        kbd_available = 1'b0;
        key_down      = 1'b0;
        idle_bus();
        repeat (2) @(negedge mclk25);
        reset_in = 1'b0;
    endtask

    // Called right after a negedge with kbd_available already driven high.
    task automatic wait_read_kb(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (read_kb) begin
                got = 1'b1;
                break;
            end
            @(negedge mclk25);
        end
        if (got) begin
            @(negedge mclk25);
            kbd_available = 1'b0;
        end
    endtask

    task automatic offer_key(input logic [6:0] c, input logic a, input int budget,
                             output bit got);
        @(negedge mclk25);
        kbd_available = 1'b1;
        ascii         = c;
        ar2           = a;
        wait_read_kb(budget, got);
    endtask

    task automatic data_read(output logic [15:0] v);
        @(negedge mclk25);
        bus_sel_data = 1'b1;
        bus_rd       = 1'b1;
        #1 v = bus_rdata;
        @(negedge mclk25);
        bus_sel_data = 1'b0;
        bus_rd       = 1'b0;
    endtask

    task automatic csr_write(input logic [15:0] d);
        @(negedge mclk25);
        bus_sel_csr = 1'b1;
        bus_wr      = 1'b1;
        bus_wdata   = d;
        @(negedge mclk25);
        idle_bus();
    endtask

    vec_t       vt [17];
    bit         got;
    logic [15:0] rv;

    // reference model state
    logic [7:0] mq [$];
    logic       m_mask, m_pend, m_ack, m_wait, m_kp;
    logic [6:0] m_hold;
    logic       if_avail, if_ar2, prev_rkb;
    logic [6:0] if_code;

    initial begin
        reset_in = 1'b1; kbd_available = 1'b0; ascii = '0; ar2 = 1'b0; key_down = 1'b0;
        idle_bus();

        //            av code  a2 kd cs dt rd wr wdata     ak rk lv ir vec    kp rdata
        vt[0]  = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        vt[1]  = mkv(1, 7'h41, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        vt[2]  = mkv(1, 7'h41, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        vt[3]  = mkv(0, 7'h00, 0, 0, 1, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 8'o060, 0, 16'o000200);
        vt[4]  = mkv(0, 7'h00, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 1, 1, 8'o060, 0, 16'h0041);
        vt[5]  = mkv(0, 7'h00, 0, 1, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0041);
        vt[6]  = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 16'h0000);
        vt[7]  = mkv(0, 7'h00, 0, 0, 1, 0, 0, 1, 16'o000100, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        vt[8]  = mkv(1, 7'h52, 1, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'o000100);
        vt[9]  = mkv(1, 7'h52, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        vt[10] = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 16'h0000);
        vt[11] = mkv(0, 7'h00, 0, 0, 1, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 16'o000300);
        vt[12] = mkv(0, 7'h00, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 8'o274, 0, 16'o000200);
        vt[13] = mkv(0, 7'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 8'o274, 0, 16'h0000);
        vt[14] = mkv(0, 7'h00, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 16'h0052);
        vt[15] = mkv(0, 7'h00, 0, 0, 0, 1, 0, 1, 16'hffff, 0, 0, 0, 0, 8'h00, 0, 16'h0052);
        vt[16] = mkv(0, 7'h00, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0052);

        // ---- vector table: capture, CSR/data reads, hold, mask, vectors ----
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i != 0) @(negedge mclk25);
            kbd_available = vt[i].avail; ascii = vt[i].code; ar2 = vt[i].a2;
            key_down = vt[i].kd; bus_sel_csr = vt[i].scsr; bus_sel_data = vt[i].sdat;
            bus_rd = vt[i].rd; bus_wr = vt[i].wr; bus_wdata = vt[i].wdata; irq_ack = vt[i].ack;
            #1;
            chk($sformatf("vec%0d read_kb", i), 32'(read_kb), 32'(vt[i].e_rkb));
            chk($sformatf("vec%0d fifo_level", i), 32'(fifo_level), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vt[i].e_irq));
            chk($sformatf("vec%0d key_pressed", i), 32'(key_pressed), 32'(vt[i].e_kp));
            chk($sformatf("vec%0d bus_rdata", i), 32'(bus_rdata), 32'(vt[i].e_rdata));
            if (vt[i].e_irq) chk($sformatf("vec%0d irq_vector", i), 32'(irq_vector), 32'(vt[i].e_vec));
        end

        // ---- FIFO full: fifth key waits in the interface, no loss ----
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            offer_key(7'(7'h61 + k), 1'b0, 6, got);
            chk($sformatf("full_take%0d", k), 32'(got), 32'd1);
        end
        @(negedge mclk25);
        kbd_available = 1'b1; ascii = 7'h65; ar2 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 if (read_kb) got = 1'b1;
            @(negedge mclk25);
        end
        chk("full_no_read_kb", 32'(got), 32'd0);
        #1 chk("full_level", 32'(fifo_level), 32'(DEPTH));
        data_read(rv);
        chk("full_first_code", 32'(rv), 32'h61);
        wait_read_kb(6, got);
        chk("full_fifth_taken", 32'(got), 32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            data_read(rv);
            chk($sformatf("full_order%0d", k), 32'(rv), 32'(7'h61 + k));
        end
        #1 chk("full_drained", 32'(fifo_level), 32'd0);

        // ---- irq_ack, then a pop that leaves an entry re-arms irq ----
        do_reset();
        offer_key(7'h11, 1'b0, 6, got);
        offer_key(7'h22, 1'b1, 6, got);
        #1 chk("ack_irq_before", 32'(irq), 32'd1);
        chk("ack_vec_first", 32'(irq_vector), 32'(8'o060));
        @(negedge mclk25); irq_ack = 1'b1;
        @(negedge mclk25); irq_ack = 1'b0;
        #1 chk("ack_irq_cleared", 32'(irq), 32'd0);
        data_read(rv);
        chk("ack_read_code", 32'(rv), 32'h11);
        #1 chk("ack_irq_rearm", 32'(irq), 32'd1);
        chk("ack_vec_second", 32'(irq_vector), 32'(8'o274));

        // ---- reset during TAKE, then recapture of the held key ----
        do_reset();
        csr_write(16'o000100);
        kbd_available = 1'b1; ascii = 7'h33; ar2 = 1'b0;
        @(negedge mclk25);
        #1 chk("rst_take_read_kb", 32'(read_kb), 32'd1);
        reset_in = 1'b1;
        @(negedge mclk25);
        reset_in = 1'b0;
        bus_sel_csr = 1'b1;
        #1 chk("rst_read_kb_low", 32'(read_kb), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_csr_mask", 32'(bus_rdata), 32'd0);
        wait_read_kb(6, got);
        chk("rst_recapture", 32'(got), 32'd1);
        bus_sel_csr = 1'b0;
        data_read(rv);
        chk("rst_recapture_code", 32'(rv), 32'h33);

        // ---- randomized run against the reference model ----
        do_reset();
        mq.delete();
        m_mask = 0; m_pend = 0; m_ack = 0; m_wait = 0; m_kp = 0; m_hold = '0;
        if_avail = 0; if_ar2 = 0; if_code = '0; prev_rkb = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          op;
            int          old_n, new_n;
            logic        push, pop, csrw, nmask, set, clr, nack, nwait;
            logic [15:0] e_rd;
            @(negedge mclk25);
            if (prev_rkb) if_avail = 1'b0;
            else if (!if_avail && $urandom_range(0, 2) == 0) begin
                if_avail = 1'b1; if_code = 7'($urandom); if_ar2 = 1'($urandom);
            end
            kbd_available = if_avail; ascii = if_code; ar2 = if_ar2;
            key_down = 1'($urandom);
            idle_bus();
            op = $urandom_range(0, 15);
            case (op)
                0, 1, 2: begin bus_sel_data = 1; bus_rd = 1; end
                3:       bus_sel_data = 1;
                4, 5:    begin bus_sel_csr = 1; bus_rd = 1; end
                6:       begin bus_sel_csr = 1; bus_wr = 1; bus_wdata = 16'($urandom); end
                7:       begin bus_sel_data = 1; bus_wr = 1; bus_wdata = 16'($urandom); end
                default: ;
            endcase
            irq_ack  = m_pend && ($urandom_range(0, 7) == 0);
            reset_in = ($urandom_range(0, 199) == 0);
            #1;
            if (bus_sel_csr) e_rd = {8'b0, (mq.size() != 0), m_mask, 6'b0};
            else if (bus_sel_data) e_rd = {9'b0, (mq.size() != 0) ? mq[0][6:0] : m_hold};
            else e_rd = 16'h0;
            chk($sformatf("rnd%0d read_kb", cyc), 32'(read_kb), 32'(m_ack));
            chk($sformatf("rnd%0d fifo_level", cyc), 32'(fifo_level), 32'(mq.size()));
            chk($sformatf("rnd%0d irq", cyc), 32'(irq), 32'(m_pend));
            chk($sformatf("rnd%0d key_pressed", cyc), 32'(key_pressed), 32'(m_kp));
            chk($sformatf("rnd%0d bus_rdata", cyc), 32'(bus_rdata), 32'(e_rd));
            if (m_pend && mq.size() != 0)
                chk($sformatf("rnd%0d irq_vector", cyc), 32'(irq_vector),
                    32'(mq[0][7] ? 8'o274 : 8'o060));
            prev_rkb = m_ack;

            if (reset_in) begin
                mq.delete();
                m_mask = 0; m_pend = 0; m_ack = 0; m_wait = 0; m_kp = 0; m_hold = '0;
            end else begin
                old_n = mq.size();
                push  = m_ack;
                pop   = bus_sel_data && bus_rd && (old_n != 0);
                new_n = old_n + int'(push) - int'(pop);
                csrw  = bus_sel_csr && bus_wr;
                nmask = csrw ? bus_wdata[6] : m_mask;
                set   = (!nmask && ((push && old_n == 0) || (pop && new_n != 0)))
                      || (csrw && m_mask && !bus_wdata[6] && old_n != 0);
                clr   = irq_ack || pop || (csrw && bus_wdata[6]);
                nack  = !m_ack && !m_wait && kbd_available && (old_n < DEPTH);
                nwait = m_ack || (m_wait && kbd_available);
                if (pop) begin
                    m_hold = mq[0][6:0];
                    void'(mq.pop_front());
                end
                if (push) mq.push_back({ar2, ascii});
                m_mask = nmask;
                m_pend = set ? 1'b1 : (clr ? 1'b0 : m_pend);
                m_ack  = nack;
                m_wait = nwait;
                m_kp   = key_down;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
